// File: rtl/bch_syndrome_count_if.sv
// Codeword word stream in, syndrome vector plus flags out, for bch_syndrome_count.
interface bch_syndrome_count_if #(
  parameter int unsigned pDAT_W = 4,
  parameter int unsigned pSYN_W = 8
);
  logic              ival;
  logic              isop;
  logic              ieop;
  logic [pDAT_W-1:0] idat;
  logic              oval;
  logic [pSYN_W-1:0] osyndrome;
  logic              oerr;
  logic              olen_err;

  modport master (
    output ival, isop, ieop, idat,
    input  oval, osyndrome, oerr, olen_err
  );

  modport slave (
    input  ival, isop, ieop, idat,
    output oval, osyndrome, oerr, olen_err
  );
endinterface

// File: rtl/bch_syndrome_count.sv
// Word-serial BCH syndrome accumulator: t odd-syndrome Horner slices, one strobe per codeword.
// Optional BCH_SYNDROME_COUNT_EVEN_EN adds S2..S2t by squaring in one extra register stage.
module bch_syndrome_count #(
  parameter int unsigned m      = 4,
  parameter int unsigned irrpol = 19,
  parameter int unsigned n      = 15,
  parameter int unsigned t      = 2,
  parameter int unsigned pDAT_W = 4
) (
  input  logic                 iclk,
  input  logic                 ireset,
  input  logic                 iclkena,
  bch_syndrome_count_if.slave  bus
);

  localparam int unsigned W     = (n + pDAT_W - 1) / pDAT_W;
  localparam int unsigned R     = n % pDAT_W;
  localparam int unsigned CNT_W = $clog2(W + 1);
`ifdef BCH_SYNDROME_COUNT_EVEN_EN
  localparam int unsigned NSYN  = 2 * t;
`else
  localparam int unsigned NSYN  = t;
`endif
  localparam logic [pDAT_W-1:0] LAST_MASK =
    (R != 0) ? pDAT_W'((1 << R) - 1) : {pDAT_W{1'b1}};

  // GF(2^m) product, shift-and-add with reduction by irrpol
  function automatic logic [m-1:0] gf_mul(input logic [m-1:0] a, input logic [m-1:0] b);
    logic [m-1:0] p;
    logic [m-1:0] x;
    p = '0;
    x = a;
    for (int unsigned k = 0; k < m; k++) begin
      if (b[k]) p = p ^ x;
      x = x[m-1] ? ({x[m-2:0], 1'b0} ^ m'(irrpol)) : {x[m-2:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [m-1:0] alpha_pow(input int unsigned e);
    logic [m-1:0] r;
    r = m'(1);
    for (int unsigned k = 0; k < e; k++) r = gf_mul(r, m'(2));
    return r;
  endfunction

  typedef enum logic {S_IDLE, S_ACC} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   accept;
  logic                   done;
  logic                   isop_word;
  logic [CNT_W-1:0]       wcnt;
  logic [CNT_W-1:0]       widx;
  logic [pDAT_W-1:0]      mask;
  logic [m-1:0]           alpha [t];
  logic [m-1:0]           slice_acc;
  logic [t-1:0][m-1:0]    sreg;
  logic [t-1:0][m-1:0]    snext;

  logic                   p_val;
  logic [t*m-1:0]         p_syn;
  logic                   p_err;
  logic                   p_len;

  for (genvar gi = 0; gi < t; gi++) begin : g_alpha
    localparam logic [m-1:0] ALPHA = alpha_pow(2 * gi + 1);
    assign alpha[gi] = ALPHA;
  end

  assign isop_word = bus.ival & bus.isop;

  // state register
  always_ff @(posedge iclk) begin
    if (ireset)       state <= S_IDLE;
    else if (iclkena) state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.ival && bus.isop && !bus.ieop) state_nxt = S_ACC;
      S_ACC:   if (bus.ival && bus.ieop)              state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // word acceptance and end-of-codeword decode
  always_comb begin
    accept = 1'b0;
    done   = 1'b0;
    case (state)
      S_IDLE: begin
        accept = bus.ival & bus.isop;
        done   = bus.ival & bus.isop & bus.ieop;
      end
      S_ACC: begin
        accept = bus.ival;
        done   = bus.ival & bus.ieop;
      end
      default: ;
    endcase
  end

  // an isop word is word 0 regardless of the counter; past W-1 nothing is folded in
  always_comb begin
    widx = isop_word ? '0 : wcnt;
    if (widx == CNT_W'(W - 1))   mask = LAST_MASK;
    else if (widx >= CNT_W'(W))  mask = '0;
    else                         mask = '1;
  end

  // Horner step per valid bit; an isop word starts from a zero state
  always_comb begin
    slice_acc = '0;
    snext     = '0;
    for (int unsigned i = 0; i < t; i++) begin
      slice_acc = isop_word ? '0 : sreg[i];
      for (int unsigned b = 0; b < pDAT_W; b++) begin
        if (mask[b]) slice_acc = gf_mul(slice_acc, alpha[i]) ^ m'(bus.idat[b]);
      end
      snext[i] = slice_acc;
    end
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      wcnt <= '0;
      sreg <= '0;
    end else if (iclkena && accept) begin
      wcnt <= (widx >= CNT_W'(W)) ? CNT_W'(W) : widx + CNT_W'(1);
      sreg <= snext;
    end
  end

  // first output stage: captures the final slice values on the eop word
  always_ff @(posedge iclk) begin
    if (ireset) begin
      p_val <= 1'b0;
      p_syn <= '0;
      p_err <= 1'b0;
      p_len <= 1'b0;
    end else if (iclkena) begin
      p_val <= done;
      if (done) begin
        p_syn <= snext;
        p_err <= |snext;
        p_len <= (widx != CNT_W'(W - 1));
      end
    end
  end

`ifdef BCH_SYNDROME_COUNT_EVEN_EN
  logic [NSYN*m-1:0] full_c;
  logic [m-1:0]      sq_v;
  int unsigned       odd_k;
  int unsigned       nsq;
  logic              q_val;
  logic [NSYN*m-1:0] q_syn;
  logic              q_err;
  logic              q_len;

  // S(k) with k = o*2^j equals S(o) squared j times
  always_comb begin
    full_c = '0;
    sq_v   = '0;
    odd_k  = 0;
    nsq    = 0;
    for (int unsigned k = 1; k <= NSYN; k++) begin
      odd_k = k;
      nsq   = 0;
      for (int unsigned j = 0; j < 8; j++) begin
        if (odd_k % 2 == 0) begin
          odd_k = odd_k / 2;
          nsq   = nsq + 1;
        end
      end
      sq_v = p_syn[((odd_k - 1) / 2) * m +: m];
      for (int unsigned j = 0; j < 8; j++) begin
        if (j < nsq) sq_v = gf_mul(sq_v, sq_v);
      end
      full_c[(k - 1) * m +: m] = sq_v;
    end
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      q_val <= 1'b0;
      q_syn <= '0;
      q_err <= 1'b0;
      q_len <= 1'b0;
    end else if (iclkena) begin
      q_val <= p_val;
      if (p_val) begin
        q_syn <= full_c;
        q_err <= |full_c;
        q_len <= p_len;
      end
    end
  end

  assign bus.oval      = q_val;
  assign bus.osyndrome = q_syn;
  assign bus.oerr      = q_err;
  assign bus.olen_err  = q_len;
`else
  assign bus.oval      = p_val;
  assign bus.osyndrome = p_syn;
  assign bus.oerr      = p_err;
  assign bus.olen_err  = p_len;
`endif

endmodule
